sc_mmio_master: RTL and testbench
=================================

Name: sc_mmio_master

Overview:
- Bus initiator for the single-cycle data memory / memory-mapped I/O port.
- Drives the responder's addr, datain and we, and captures its dataout.
- Turns a valid/ready command (read or write burst of 1..MAX_BURST words) into one bus beat per clock.
- Sits between a test/boot sequencer or debug host and the data-memory/I-O block, in place of the CPU's data port.

Parameters:
- MAX_BURST, 16, maximum beats per command; cmd_len is clog2(MAX_BURST)+1 bits wide.
- IO_PAGE, 24'hffffff, value of addr[31:8] that selects the I/O page.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  start byte address.
- cmd_len  in  5  beat count, 1..16.
- wr_valid  in  1  write data available.
- wr_ready  out  1  write beat accepted this cycle.
- wr_data  in  32  write data.
- rd_valid  out  1  one-cycle pulse: rd_data holds a read beat.
- rd_data  out  32  read data.
- done  out  1  one-cycle pulse: command complete.
- err  out  1  one-cycle pulse: command rejected, no beats issued.
- busy  out  1  command in progress.
- addr  out  32  bus address to the responder.
- datain  out  32  bus write data.
- we  out  1  bus write enable.
- dataout  in  32  bus read data from the responder.

Behaviour:
- Reset (synchronous, active-high), taking effect at the next edge even mid-burst:
  - state = IDLE, addr = 0, datain = 0, we = 0.
  - rd_valid = done = err = busy = 0, rd_data = 0.
  - Any burst in progress is abandoned and no done is generated.
- All bus outputs and status outputs are registered. wr_ready is combinational.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch write/addr/len, compute the stride, then validate.
  - Stride is 0x10 if cmd_addr[31:8] == IO_PAGE, else 4.
  - Rejected with an err pulse the next cycle, staying in IDLE, if cmd_len == 0, cmd_len > MAX_BURST, or a dram burst end (33-bit addr + 4*(len-1)) reaches the I/O page or beyond.
  - Otherwise go to RUN with busy = 1.
- RUN, write:
  - wr_ready = 1.
  - On wr_valid at edge k, register addr = beat address, datain = wr_data, we = 1 for cycle k..k+1.
  - No wr_valid means we = 0 that cycle (bubble) and the address does not advance.
- RUN, read:
  - One beat per cycle with no stall: addr = beat address, we = 0.
  - dataout is sampled at the following edge into rd_data with rd_valid = 1.
  - Read latency from beat issue to rd_valid is exactly 1 cycle.
- Address advance:
  - dram region: 32-bit add of 4.
  - I/O region: only addr[7:0] adds 0x10, modulo 256; addr[31:8] stays IO_PAGE. 0xfffffff0 wraps to 0xffffff00.
- Last beat presented in cycle k:
  - At edge k+1: we = 0, done = 1, busy = 0, state = IDLE, cmd_ready = 1.
  - For reads, done coincides with the final rd_valid.
  - A new command may be accepted in cycle k+1, so back-to-back bursts have a 1-cycle gap.
- Beat counter counts down from len. There is no rd backpressure: the consumer must take each rd_valid pulse.
- cmd_valid during RUN is ignored (cmd_ready = 0).

Optional Feature:
- SC_MMIO_ALIGN_CHK_EN defined:
  - Commands with cmd_addr[1:0] != 0 (dram) or cmd_addr[3:0] != 0 (I/O page) are rejected with an err pulse.
- SC_MMIO_ALIGN_CHK_EN undefined:
  - Those low address bits are silently forced to zero.
  - The burst proceeds normally.

Test Plan:
- Reset, then write cmd_addr=0x0, len=4 with wr_data 0x11,0x22,0x33,0x44 continuous -> we high 4 cycles at addr 0x0,0x4,0x8,0xC; done in cycle 5.
- Read the same burst -> rd_valid 4 consecutive cycles with 0x11..0x44, each 1 cycle after its beat; done with the last rd_valid.
- I/O write at 0xffffff50, len=3 -> we at 0xffffff50, 0xffffff60, 0xffffff70; read at 0xfffffff0, len=2 -> addr 0xfffffff0 then 0xffffff00.
- Write burst with wr_valid low for 2 cycles mid-burst -> we low 2 cycles, address held, 4 beats total; done after the last beat.
- cmd_len=0; cmd_addr=0xfffffef8 with len=4 -> err pulse, no we/rd_valid, cmd_ready stays 1.
- Assert reset during beat 2 of a read len=8 -> next cycle we=0, busy=0, no further rd_valid, no done; cmd_ready=1 after reset drops.

Source files
------------

// File: rtl/sc_mmio_master.sv
// Burst initiator for the single-cycle data memory / MMIO port: one bus beat per clock.
// Define SC_MMIO_ALIGN_CHK_EN to reject misaligned start addresses instead of truncating them.
module sc_mmio_master #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [23:0] IO_PAGE   = 24'hffffff
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [31:0]                 cmd_addr,
  input  logic [$clog2(MAX_BURST):0]  cmd_len,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [31:0]                 wr_data,
  output logic                        rd_valid,
  output logic [31:0]                 rd_data,
  output logic                        done,
  output logic                        err,
  output logic                        busy,
  output logic [31:0]                 addr,
  output logic [31:0]                 datain,
  output logic                        we,
  input  logic [31:0]                 dataout
);

  localparam int unsigned LEN_W   = $clog2(MAX_BURST) + 1;
  localparam logic [32:0] IO_BASE = {1'b0, IO_PAGE, 8'h00};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               is_write_q, is_write_d;
  logic               is_io_q, is_io_d;
  logic [31:0]        beat_addr_q, beat_addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [31:0]        addr_d, datain_d, rd_data_d;
  logic               we_d, rd_valid_d, done_d, err_d, busy_d;

  logic               cmd_io_c;
  logic [31:0]        cmd_base_c;
  logic [32:0]        len_m1_c;
  logic [32:0]        dram_end_c;
  logic               cmd_bad_c;
  logic [31:0]        next_beat_c;

  // Command decode: region, aligned start address and the reject conditions.
  always_comb begin
    cmd_io_c   = (cmd_addr[31:8] == IO_PAGE);
    cmd_base_c = cmd_addr & (cmd_io_c ? 32'hffff_fff0 : 32'hffff_fffc);
    len_m1_c   = 33'(cmd_len) - 33'd1;
    dram_end_c = 33'(cmd_base_c) + (len_m1_c << 2);
    cmd_bad_c  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_BURST)) ||
                 (!cmd_io_c && (dram_end_c >= IO_BASE));
`ifdef SC_MMIO_ALIGN_CHK_EN
    if (cmd_io_c ? (cmd_addr[3:0] != 4'h0) : (cmd_addr[1:0] != 2'b00)) begin
      cmd_bad_c = 1'b1;
    end
`endif
  end

  // I/O page addresses wrap inside the page; dram addresses advance linearly.
  always_comb begin
    next_beat_c = is_io_q ? {beat_addr_q[31:8], beat_addr_q[7:0] + 8'h10}
                          : beat_addr_q + 32'd4;
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_RUN) && is_write_q && (cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    is_io_d     = is_io_q;
    beat_addr_d = beat_addr_q;
    cnt_d       = cnt_q;
    rd_pend_d   = 1'b0;
    addr_d      = addr;
    datain_d    = datain;
    we_d        = 1'b0;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_pend_q ? dataout : rd_data;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d     = ST_RUN;
            busy_d      = 1'b1;
            is_write_d  = cmd_write;
            is_io_d     = cmd_io_c;
            beat_addr_d = cmd_base_c;
            cnt_d       = cmd_len;
          end
        end
      end
      ST_RUN: begin
        // cnt_q == 0 means the final beat is on the bus this cycle.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (!is_write_q || wr_valid) begin
          addr_d      = beat_addr_q;
          we_d        = is_write_q;
          datain_d    = is_write_q ? wr_data : datain;
          rd_pend_d   = !is_write_q;
          beat_addr_d = next_beat_c;
          cnt_d       = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_write_q  <= 1'b0;
      is_io_q     <= 1'b0;
      beat_addr_q <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      addr        <= '0;
      datain      <= '0;
      we          <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      is_io_q     <= is_io_d;
      beat_addr_q <= beat_addr_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      addr        <= addr_d;
      datain      <= datain_d;
      we          <= we_d;
      rd_valid    <= rd_valid_d;
      rd_data     <= rd_data_d;
      done        <= done_d;
      err         <= err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_sc_mmio_master.sv
// Scoreboard bench for sc_mmio_master with a single-cycle memory model as responder.
module tb_sc_mmio_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [4:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, err, busy;
  logic [31:0] addr, datain, dataout;
  logic        we;

  sc_mmio_master dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .busy(busy),
    .addr(addr), .datain(datain), .we(we), .dataout(dataout)
  );

  always #5 clock = ~clock;

  // Responder: combinational read, write on the clock edge, preset pattern on reset.
  logic [31:0] mem [256];
  assign dataout = mem[addr[9:2]];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'ha500_0000 | 32'(i);
    end else if (we) begin
      mem[addr[9:2]] <= datain;
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } beat_t;
  beat_t exp_wr[$];
  beat_t exp_rd[$];
  bit    exp_done[$];
  bit    exp_err[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, accept_cyc = 0, done_cyc = 0;
  int n_done = 0, n_err = 0;
  logic [31:0] prev_addr = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not expected / not seen (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clock) begin
    beat_t b;
    bit    rd;
    if (we) begin
      if (exp_wr.size() == 0) flag("bus_write_unexpected");
      else begin
        b = exp_wr.pop_front();
        chk("bus_write_addr", addr, b.a);
        chk("bus_write_data", datain, b.d);
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) flag("rd_valid_unexpected");
      else begin
        b = exp_rd.pop_front();
        chk("rd_beat_addr", prev_addr, b.a);
        chk("rd_data", rd_data, b.d);
      end
    end
    if (done) begin
      done_cyc = cyc;
      n_done++;
      if (exp_done.size() == 0) flag("done_unexpected");
      else begin
        rd = exp_done.pop_front();
        chk("done_with_rd_valid", 32'(rd_valid), 32'(rd));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (err) begin
      n_err++;
      if (exp_err.size() == 0) flag("err_unexpected");
      else begin
        void'(exp_err.pop_front());
        chk("busy_at_err", 32'(busy), 32'd0);
      end
    end
    prev_addr = addr;
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [4:0] l);
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clock); #1;
    accept_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lat);
    int s = n_done;
    int k = 0;
    while (n_done == s && k < 40) begin @(negedge clock); #1; k++; end
    if (n_done == s) flag({nm, "_done_timeout"});
    else chk({nm, "_done_latency"}, 32'(done_cyc - accept_cyc), 32'(lat));
  endtask

  task automatic wait_err(input string nm);
    int s = n_err;
    int k = 0;
    while (n_err == s && k < 10) begin @(negedge clock); #1; k++; end
    if (n_err == s) flag({nm, "_err_timeout"});
    chk({nm, "_cmd_ready_after_err"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic wr_beat(input logic [31:0] a, input logic [31:0] d);
    exp_wr.push_back('{a: a, d: d});
    wr_valid = 1'b1; wr_data = d;
    @(posedge clock); #1;
    wr_valid = 1'b0;
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d);
    exp_rd.push_back('{a: a, d: d});
  endtask

  initial begin
    logic [31:0] wa [4];
    logic [31:0] wd [4];
    wa[0] = 32'h0; wa[1] = 32'h4; wa[2] = 32'h8; wa[3] = 32'hc;
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_datain", datain, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    @(negedge clock); #1;

    // dram write burst, continuous data
    send_cmd(1'b1, 32'h0, 5'd4);
    chk("wr_ready_in_run", 32'(wr_ready), 32'd1);
    chk("busy_in_run", 32'(busy), 32'd1);
    exp_done.push_back(1'b0);
    for (int i = 0; i < 4; i++) wr_beat(wa[i], wd[i]);
    chk("wr_ready_after_last", 32'(wr_ready), 32'd0);
    wait_done("dram_wr", 5);

    // read it back
    exp_done.push_back(1'b1);
    for (int i = 0; i < 4; i++) push_rd(wa[i], wd[i]);
    send_cmd(1'b0, 32'h0, 5'd4);
    wait_done("dram_rd", 5);

    // I/O page write then a wrapping read
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 32'hffffff50, 5'd3);
    wr_beat(32'hffffff50, 32'ha1);
    wr_beat(32'hffffff60, 32'ha2);
    wr_beat(32'hffffff70, 32'ha3);
    wait_done("io_wr", 4);

    exp_done.push_back(1'b1);
    push_rd(32'hfffffff0, 32'ha50000fc);
    push_rd(32'hffffff00, 32'ha50000c0);
    send_cmd(1'b0, 32'hfffffff0, 5'd2);
    wait_done("io_rd_wrap", 3);

    // write with a two-cycle wr_valid gap
    exp_done.push_back(1'b0);
    send_cmd(1'b1, 32'h100, 5'd4);
    wr_beat(32'h100, 32'hb0);
    wr_beat(32'h104, 32'hb1);
    repeat (2) begin
      @(posedge clock); #1;
      chk("bubble_we", 32'(we), 32'd0);
      chk("bubble_addr_held", addr, 32'h104);
    end
    wr_beat(32'h108, 32'hb2);
    wr_beat(32'h10c, 32'hb3);
    wait_done("bubble_wr", 7);

    // rejected commands
    exp_err.push_back(1'b1);
    send_cmd(1'b1, 32'h0, 5'd0);
    wait_err("len_zero");
    exp_err.push_back(1'b1);
    send_cmd(1'b0, 32'hfffffef8, 5'd4);
    wait_err("dram_into_io");
    exp_err.push_back(1'b1);
    send_cmd(1'b0, 32'h0, 5'd17);
    wait_err("len_too_big");

    // last legal dram burst below the I/O page
    exp_done.push_back(1'b1);
    push_rd(32'hfffffef0, 32'ha50000bc);
    push_rd(32'hfffffef4, 32'ha50000bd);
    push_rd(32'hfffffef8, 32'ha50000be);
    push_rd(32'hfffffefc, 32'ha50000bf);
    send_cmd(1'b0, 32'hfffffef0, 5'd4);
    wait_done("dram_edge_rd", 5);

    // misaligned start
`ifdef SC_MMIO_ALIGN_CHK_EN
    exp_err.push_back(1'b1);
    send_cmd(1'b0, 32'h2, 5'd1);
    wait_err("misaligned");
`else
    exp_done.push_back(1'b1);
    push_rd(32'h0, 32'h11);
    send_cmd(1'b0, 32'h2, 5'd1);
    wait_done("misaligned_rd", 2);
`endif

    // reset during beat 2 of a read burst
    push_rd(32'h0, 32'h11);
    push_rd(32'h4, 32'h22);
    send_cmd(1'b0, 32'h0, 5'd8);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (12) @(posedge clock);
    #1;

    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);
    chk("err_left", 32'(exp_err.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
